// File: rtl/usr_shift_sequencer_pkg.sv
// Shared definitions for the universal shift register and its command sequencer.
package usr_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_CAPTURE,
        S_RESP
    } seq_state_e;

endpackage

// File: rtl/usr_shift_reg.sv
// Universal shift register: hold, shift right/left with zero fill, parallel load.
module usr_shift_reg
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            case (mode)
                MODE_SHR:  q_q <= {1'b0, q_q[WIDTH-1:1]};
                MODE_SHL:  q_q <= {q_q[WIDTH-2:0], 1'b0};
                MODE_LOAD: q_q <= d;
                default:   q_q <= q_q;
            endcase
        end
    end

    assign q = q_q;

endmodule

// File: rtl/usr_top.sv
// Sequencer plus universal shift register sharing clock and reset.
module usr_top #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_count,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy
);

    logic [1:0]       mode;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;

    usr_shift_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_seq (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .cmd_dir   (cmd_dir),
        .cmd_count (cmd_count),
        .mode      (mode),
        .d         (d),
        .q         (q),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    usr_shift_reg #(.WIDTH(WIDTH)) u_reg (
        .clk   (clk),
        .reset (reset),
        .mode  (mode),
        .d     (d),
        .q     (q)
    );

endmodule

// File: rtl/usr_shift_sequencer.sv
// Command sequencer driving a universal shift register through load, shift and capture,
// returning the final register value over a valid/ready response.
module usr_shift_sequencer
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_count,
    output logic [1:0]       mode,
    output logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] q,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy
);

    seq_state_e       state_q;
    logic [1:0]       mode_q;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic             rsp_valid_q;
    logic             busy_q;
    logic             cmd_ready_q;
    logic             dir_q;
    logic [CNT_W-1:0] cnt_q;

    // Outputs are registered alongside the state, so each is set for the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            mode_q      <= MODE_HOLD;
            d_q         <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            dir_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        d_q         <= cmd_data;
                        dir_q       <= cmd_dir;
                        cnt_q       <= cmd_count;
                        mode_q      <= MODE_LOAD;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (cnt_q != '0) begin
                        mode_q  <= dir_q ? MODE_SHL : MODE_SHR;
                        state_q <= S_SHIFT;
                    end else begin
                        mode_q  <= MODE_HOLD;
                        state_q <= S_CAPTURE;
                    end
                end
                S_SHIFT: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        mode_q  <= MODE_HOLD;
                        state_q <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    rsp_data_q  <= q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    mode_q      <= MODE_HOLD;
                    rsp_valid_q <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign mode      = mode_q;
    assign d         = d_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_usr_shift_sequencer.sv
// Directed self-checking bench for usr_shift_sequencer driving a universal shift register.
module tb_usr_shift_sequencer;
    import usr_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_data;
    logic       cmd_dir;
    logic [2:0] cmd_count;
    logic [1:0] mode;
    logic [3:0] d;
    logic [3:0] q;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_data;
    logic       busy;

    int checks = 0;
    int errors = 0;

    usr_shift_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .cmd_dir   (cmd_dir),
        .cmd_count (cmd_count),
        .mode      (mode),
        .d         (d),
        .q         (q),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    usr_shift_reg #(.WIDTH(4)) u_reg (
        .clk   (clk),
        .reset (reset),
        .mode  (mode),
        .d     (d),
        .q     (q)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full command with rsp_ready held high; exp is the hand-computed result.
    task automatic run_cmd(input logic [3:0] data, input logic dir, input logic [2:0] cnt,
                           input logic [3:0] exp, input string name);
        logic [1:0] shm;
        shm = dir ? 2'b10 : 2'b01;
        rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_data = data; cmd_dir = dir; cmd_count = cnt;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL %s_idle_ready: got %b want 1", name, cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
        checks++;
        if ({mode, d, busy, cmd_ready} !== {2'b11, data, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL %s_load: mode=%b d=%b busy=%b rdy=%b want mode=11 d=%b busy=1 rdy=0",
                     name, mode, d, busy, cmd_ready, data);
        end
        for (int i = 0; i < int'(cnt); i++) begin
            tick();
            checks++;
            if (mode !== shm) begin
                errors++; $display("FAIL %s_shift%0d: mode=%b want %b", name, i, mode, shm);
            end
        end
        tick();
        checks++;
        if ({mode, rsp_valid} !== {2'b00, 1'b0}) begin
            errors++; $display("FAIL %s_capture: mode=%b rsp_valid=%b want 00/0", name, mode, rsp_valid);
        end
        tick();
        checks++;
        if ({rsp_valid, rsp_data, mode} !== {1'b1, exp, 2'b00}) begin
            errors++;
            $display("FAIL %s_resp: valid=%b data=%b mode=%b want 1 %b 00", name, rsp_valid, rsp_data, mode, exp);
        end
        tick();
        checks++;
        if ({rsp_valid, cmd_ready, busy} !== 3'b010) begin
            errors++;
            $display("FAIL %s_idle: valid=%b rdy=%b busy=%b want 0 1 0", name, rsp_valid, cmd_ready, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b0; cmd_data = 4'h0; cmd_dir = 1'b0; cmd_count = 3'd0; rsp_ready = 1'b0;
        #12;
        checks++;
        if ({mode, d, rsp_data, rsp_valid, busy, q} !== {2'b00, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0}) begin
            errors++;
            $display("FAIL reset_state: mode=%b d=%b rsp=%b valid=%b busy=%b q=%b want all zero",
                     mode, d, rsp_data, rsp_valid, busy, q);
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({cmd_ready, busy} !== 2'b10) begin
            errors++; $display("FAIL reset_release: rdy=%b busy=%b want 1 0", cmd_ready, busy);
        end
    endtask

    task automatic test_basic_shifts();
        run_cmd(4'b1010, 1'b0, 3'd1, 4'b0101, "shr1");
        run_cmd(4'b1010, 1'b1, 3'd1, 4'b0100, "shl1");
        run_cmd(4'b1010, 1'b0, 3'd0, 4'b1010, "cnt0");
        run_cmd(4'b1111, 1'b0, 3'd5, 4'b0000, "shr5");
        run_cmd(4'b1000, 1'b0, 3'd3, 4'b0001, "shr3");
        run_cmd(4'b0011, 1'b1, 3'd2, 4'b1100, "shl2");
        run_cmd(4'b0001, 1'b1, 3'd7, 4'b0000, "shl7");
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_data = 4'b0110; cmd_dir = 1'b1; cmd_count = 3'd1;
        tick();
        cmd_data = 4'b1111; cmd_dir = 1'b0; cmd_count = 3'd0;
        tick(); tick(); tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({rsp_valid, rsp_data, cmd_ready, busy, mode} !== {1'b1, 4'b1100, 1'b0, 1'b1, 2'b00}) begin
                errors++;
                $display("FAIL bp_hold%0d: valid=%b data=%b rdy=%b busy=%b mode=%b want 1 1100 0 1 00",
                         i, rsp_valid, rsp_data, cmd_ready, busy, mode);
            end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        checks++;
        if ({rsp_valid, cmd_ready, busy, mode} !== {1'b0, 1'b1, 1'b0, 2'b00}) begin
            errors++;
            $display("FAIL bp_release: valid=%b rdy=%b busy=%b mode=%b want 0 1 0 00", rsp_valid, cmd_ready, busy, mode);
        end
        tick();
        cmd_valid = 1'b0;
        checks++;
        if ({mode, d, busy} !== {2'b11, 4'b1111, 1'b1}) begin
            errors++; $display("FAIL bp_next_accept: mode=%b d=%b busy=%b want 11 1111 1", mode, d, busy);
        end
        tick(); tick();
        checks++;
        if ({rsp_valid, rsp_data} !== {1'b1, 4'b1111}) begin
            errors++; $display("FAIL bp_next_resp: valid=%b data=%b want 1 1111", rsp_valid, rsp_data);
        end
        tick();
    endtask

    task automatic test_reset_mid_shift();
        rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_data = 4'b1010; cmd_dir = 1'b0; cmd_count = 3'd3;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        checks++;
        if ({mode, q} !== {2'b01, 4'b0101}) begin
            errors++; $display("FAIL mid_pre: mode=%b q=%b want 01 0101", mode, q);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({mode, busy, rsp_valid, q} !== {2'b00, 1'b0, 1'b0, 4'h0}) begin
            errors++;
            $display("FAIL mid_reset: mode=%b busy=%b valid=%b q=%b want 00 0 0 0000", mode, busy, rsp_valid, q);
        end
        #3;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({rsp_valid, busy, mode} !== {1'b0, 1'b0, 2'b00}) begin
                errors++;
                $display("FAIL mid_no_rsp%0d: valid=%b busy=%b mode=%b want 0 0 00", i, rsp_valid, busy, mode);
            end
        end
        run_cmd(4'b1100, 1'b0, 3'd2, 4'b0011, "after_rst");
    endtask

    initial begin
        test_reset();
        test_basic_shifts();
        test_backpressure();
        test_reset_mid_shift();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/usr_shift_sequencer.md
# usr_shift_sequencer

Command sequencer sitting directly upstream of the 4-bit universal shift register. Accepts a shift command (data word, direction, count) over a valid/ready handshake, drives the register's `mode`/`d` inputs through load → shift → hold, then returns the register's final `q` as a response with its own valid/ready handshake. The sequencer and the register share `clk` and `reset`.

## Interface
- `WIDTH`, 4: data width; must match the shift register.
- `CNT_W`, 3: width of the shift-count field. Legal counts are 0 to 2^CNT_W−1.
- `clk`  in  1  rising-edge clock, shared with the shift register.
- `reset`  in  1  asynchronous, active-high reset, shared with the shift register.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer can accept a command.
- `cmd_data`  in  WIDTH  word to parallel-load.
- `cmd_dir`  in  1  0 = shift right, 1 = shift left.
- `cmd_count`  in  CNT_W  number of shift cycles.
- `mode`  out  2  register mode: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- `d`  out  WIDTH  register parallel-load data.
- `q`  in  WIDTH  register output.
- `rsp_valid`  out  1  result present.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_data`  out  WIDTH  register value after the last shift.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, LOAD, SHIFT, CAPTURE, RESP.
- **IDLE:** `cmd_ready`=1 and `mode`=00. When `cmd_valid`=1, the command is accepted: latch `cmd_data`, `cmd_dir` and `cmd_count`, then go to LOAD.
- **LOAD:** drive `mode`=11 and `d`=latched data for exactly one cycle. Go to SHIFT if count≠0, otherwise go to CAPTURE.
- **SHIFT:** drive `mode`=01 (dir=0) or 10 (dir=1) for exactly `count` cycles. A down-counter is loaded with the count on acceptance. Leave SHIFT on the cycle the counter reaches 1.
- **CAPTURE:** `mode`=00. Register `q` into `rsp_data` at the closing edge, then go to RESP.
- **RESP:** `rsp_valid`=1 with `rsp_data` held stable until `rsp_ready`=1, then go to IDLE. `rsp_ready` is ignored in every other state.
- `mode` is 00 in every state other than LOAD and SHIFT, so the register never shifts spuriously.
- `d` holds the latched data from acceptance until the next acceptance. `d` is a don't-care outside LOAD.
- The register fills vacated bits with 0. Counts ≥ WIDTH therefore yield all zeros. This is legal and must not be clamped.
- No new command is accepted while `busy`=1. There is no command queueing.

## Timing
- Acceptance edge T0 → LOAD during cycle T0..T1 → SHIFT during T1..T1+count → CAPTURE for one cycle → `rsp_valid` high count+2 cycles after T0.
- Minimum command-to-response time is 2 cycles (count=0). Maximum is 2^CNT_W+1 cycles.
- With `rsp_ready` held high, `cmd_ready` reasserts count+3 cycles after T0. Back-to-back throughput is therefore one command per count+3 cycles.
- Reset, asynchronous: state=IDLE, `mode`=00, `d`=0, `rsp_data`=0, `rsp_valid`=0, `busy`=0, counter=0. `cmd_ready`=1 from the first edge after deassertion.
- Reset mid-operation in any state aborts the command with no response. Because the register shares the reset, `q`=0 afterwards.
- `cmd_valid` held high through RESP is not accepted until the cycle after the RESP→IDLE edge.

## Structure
- Shared package `usr_pkg` holds:
  - mode constants `MODE_HOLD`=2'b00, `MODE_SHR`=2'b01, `MODE_SHL`=2'b10, `MODE_LOAD`=2'b11, also used by the register and the benches;
  - the FSM state encoding.
- Single module with no sub-modules; the shift down-counter is inline.
- A thin top-level, `usr_top`, instantiates the sequencer and the universal register and is the verification target.

## Test plan
- Data 1010, dir=0, count=1 → `mode` sequence 11, 01, 00; `rsp_data`=0101 three cycles after acceptance.
- Data 1010, dir=1, count=1 → `rsp_data`=0100.
- Data 1010, count=0 → `mode` sequence 11, 00 with no shift cycle; `rsp_data`=1010 two cycles after acceptance.
- Data 1111, dir=0, count=5 → five cycles of `mode`=01; `rsp_data`=0000.
- Hold `rsp_ready`=0 for 4 cycles in RESP → `rsp_valid` and `rsp_data` stay stable, `cmd_ready`=0, and a pending `cmd_valid` is not accepted. Release → IDLE on the next edge.
- Assert `reset` during SHIFT (count=3, after 1 shift) → `mode`=00, `busy`=0 and `rsp_valid`=0 immediately; no response is produced; the next command completes normally.
